// File: rtl/vrf_wb_arbiter.sv
// Shares the single VRF write port between the lane ALU and the load-return path.
// Each source has a one-entry holding register; the write-back stage is registered.
module vrf_wb_arbiter #(
  parameter int unsigned NUMBER_VECTOR_LANES = 4,
  parameter int unsigned LANES_DATA_WIDTH    = 64,
  parameter int unsigned MAX_WAIT            = 4,
  localparam int unsigned DW = NUMBER_VECTOR_LANES * LANES_DATA_WIDTH,
  localparam int unsigned MW = DW / 8,
  localparam int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [RW-1:0] alu_dest,
  input  logic [DW-1:0] alu_data,
  input  logic [MW-1:0] alu_wmask,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [RW-1:0] mem_dest,
  input  logic [DW-1:0] mem_data,
  input  logic [MW-1:0] mem_wmask,
  output logic          wb_valid,
  output logic [RW-1:0] wb_dest,
  output logic [DW-1:0] wb_data,
  output logic [MW-1:0] wb_mask,
  output logic          wb_src,
  output logic          operation_done,
  output logic [RW-1:0] register_to_write,
  output logic          read_done,
  output logic [RW-1:0] destination_id_out
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic          hold_alu_v;
  logic [RW-1:0] hold_alu_dest;
  logic [DW-1:0] hold_alu_data;
  logic [MW-1:0] hold_alu_mask;
  logic          hold_mem_v;
  logic [RW-1:0] hold_mem_dest;
  logic [DW-1:0] hold_mem_data;
  logic [MW-1:0] hold_mem_mask;
  logic [CW-1:0] wait_cnt;
  logic          grant_alu_c;
  logic          grant_mem_c;

  // Memory wins contention unless the ALU entry has aged out.
  always_comb begin
    grant_alu_c = 1'b0;
    grant_mem_c = 1'b0;
    if (hold_alu_v && hold_mem_v) begin
      if (wait_cnt == CW'(MAX_WAIT)) grant_alu_c = 1'b1;
      else                           grant_mem_c = 1'b1;
    end else begin
      grant_alu_c = hold_alu_v;
      grant_mem_c = hold_mem_v;
    end
  end

  // A draining entry can be refilled in the same cycle.
  assign alu_ready = !hold_alu_v || grant_alu_c;
  assign mem_ready = !hold_mem_v || grant_mem_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_alu_v    <= 1'b0;
      hold_alu_dest <= '0;
      hold_alu_data <= '0;
      hold_alu_mask <= '0;
    end else if (alu_valid && alu_ready) begin
      hold_alu_v    <= 1'b1;
      hold_alu_dest <= alu_dest;
      hold_alu_data <= alu_data;
      hold_alu_mask <= alu_wmask;
    end else if (grant_alu_c) begin
      hold_alu_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_mem_v    <= 1'b0;
      hold_mem_dest <= '0;
      hold_mem_data <= '0;
      hold_mem_mask <= '0;
    end else if (mem_valid && mem_ready) begin
      hold_mem_v    <= 1'b1;
      hold_mem_dest <= mem_dest;
      hold_mem_data <= mem_data;
      hold_mem_mask <= mem_wmask;
    end else if (grant_mem_c) begin
      hold_mem_v    <= 1'b0;
    end
  end

  // Counts consecutive lost arbitrations of a pending ALU entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!hold_alu_v || grant_alu_c) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CW'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // Write-back stage; payload holds its last value while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid           <= 1'b0;
      wb_dest            <= '0;
      wb_data            <= '0;
      wb_mask            <= '0;
      wb_src             <= 1'b0;
      operation_done     <= 1'b0;
      register_to_write  <= '0;
      read_done          <= 1'b0;
      destination_id_out <= '0;
    end else begin
      wb_valid           <= grant_alu_c || grant_mem_c;
      operation_done     <= grant_alu_c;
      read_done          <= grant_mem_c;
      register_to_write  <= grant_alu_c ? hold_alu_dest : '0;
      destination_id_out <= grant_mem_c ? hold_mem_dest : '0;
      if (grant_mem_c) begin
        wb_dest <= hold_mem_dest;
        wb_data <= hold_mem_data;
        wb_mask <= hold_mem_mask;
        wb_src  <= 1'b1;
      end else if (grant_alu_c) begin
        wb_dest <= hold_alu_dest;
        wb_data <= hold_alu_data;
        wb_mask <= hold_alu_mask;
        wb_src  <= 1'b0;
      end
    end
  end

endmodule
